// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg : shared width default and control/status bundles for the multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic ld;
    logic enShift;
    logic addA;
    logic clrOut;
    logic flipEnd;
  } mult_ctrl_t;

  typedef struct packed {
    logic lsb1;
    logic doneAdd;
    logic flipA;
    logic flipB;
  } mult_stat_t;

endpackage

`default_nettype wire

// File: rtl/mult_datapath_iter_counter.sv
// ---------------------------------------------------------------------------
// iter_counter : iteration counter with synchronous clear, saturating at MAX
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iter_counter #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          done
);

  logic [CW-1:0] count_r;

  assign done  = (count_r == CW'(MAX));
  assign count = count_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && !done) begin
      count_r <= count_r + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_datapath.sv
// ---------------------------------------------------------------------------
// mult_datapath : shift-add datapath (operand magnitudes, accumulator, sign fix)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               ld,
  input  logic               enShift,
  input  logic               addA,
  input  logic               clrOut,
  input  logic               flipEnd,
  output logic               lsb1,
  output logic               doneAdd,
  output logic               flipA,
  output logic               flipB,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  mult_ctrl_t ctrl;
  mult_stat_t stat;

  logic [WIDTH-1:0] mag_a_r, mag_a_n;
  logic [WIDTH-1:0] reg_b_r, reg_b_n;
  logic             flip_a_r, flip_a_n;
  logic             flip_b_r, flip_b_n;
  logic [PW-1:0]    product_r, product_n;
  logic [CW-1:0]    count;
  logic             count_done;
  logic             step;

  assign ctrl = '{ld: ld, enShift: enShift, addA: addA, clrOut: clrOut, flipEnd: flipEnd};

  // An iteration only happens while the counter has room and no reload is pending.
  assign step = ctrl.enShift && !count_done && !ctrl.ld;

  iter_counter #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (ctrl.ld),
    .en    (step),
    .count (count),
    .done  (count_done)
  );

  always_comb begin
    mag_a_n   = mag_a_r;
    reg_b_n   = reg_b_r;
    flip_a_n  = flip_a_r;
    flip_b_n  = flip_b_r;
    product_n = product_r;

    if (ctrl.ld) begin
      // The most negative operand maps to 2^(WIDTH-1), which fits unsigned.
      mag_a_n  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
      reg_b_n  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
      flip_a_n = a[WIDTH-1];
      flip_b_n = b[WIDTH-1];
    end else if (step) begin
      reg_b_n = reg_b_r >> 1;
    end

    if (ctrl.clrOut) begin
      product_n = '0;
    end else if (ctrl.flipEnd) begin
      product_n = ~product_r + PW'(1);
    end else if (ctrl.enShift && !count_done && ctrl.addA) begin
      product_n = product_r + ({{WIDTH{1'b0}}, mag_a_r} << count);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_a_r   <= '0;
      reg_b_r   <= '0;
      flip_a_r  <= 1'b0;
      flip_b_r  <= 1'b0;
      product_r <= '0;
    end else begin
      mag_a_r   <= mag_a_n;
      reg_b_r   <= reg_b_n;
      flip_a_r  <= flip_a_n;
      flip_b_r  <= flip_b_n;
      product_r <= product_n;
    end
  end

  assign stat = '{lsb1: reg_b_r[0], doneAdd: count_done, flipA: flip_a_r, flipB: flip_b_r};

  assign lsb1    = stat.lsb1;
  assign doneAdd = stat.doneAdd;
  assign flipA   = stat.flipA;
  assign flipB   = stat.flipB;
  assign product = product_r;

endmodule

`default_nettype wire

// File: tb/tb_mult_datapath.sv
// ---------------------------------------------------------------------------
// tb_mult_datapath : directed self-checking bench for mult_datapath (WIDTH=8)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult_datapath;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ld = 1'b0;
  logic          enShift = 1'b0;
  logic          addA = 1'b0;
  logic          clrOut = 1'b0;
  logic          flipEnd = 1'b0;
  logic          lsb1;
  logic          doneAdd;
  logic          flipA;
  logic          flipB;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  mult_datapath #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .ld      (ld),
    .enShift (enShift),
    .addA    (addA),
    .clrOut  (clrOut),
    .flipEnd (flipEnd),
    .lsb1    (lsb1),
    .doneAdd (doneAdd),
    .flipA   (flipA),
    .flipB   (flipB),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av; b = bv; ld = 1'b1; clrOut = 1'b1;
    step();
    ld = 1'b0; clrOut = 1'b0;
  endtask

  task automatic shift(input logic add);
    enShift = 1'b1; addA = add;
    step();
    enShift = 1'b0; addA = 1'b0;
  endtask

  task automatic flip();
    flipEnd = 1'b1;
    step();
    flipEnd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total++;
    if ({lsb1, doneAdd, flipA, flipB, product} !== 20'h0) begin
      bad++;
      $display("FAIL reset_state: got lsb1=%b done=%b fA=%b fB=%b prod=%h, want all 0",
               lsb1, doneAdd, flipA, flipB, product);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_pos_pos();
    int bm = 5;
    load(8'd3, 8'd5);
    total++;
    if ({flipA, flipB} !== 2'b00) begin
      bad++; $display("FAIL pp_flags: got %b%b want 00", flipA, flipB);
    end
    // addA alone (idle FSM) must not accumulate
    addA = 1'b1; step(); step(); addA = 1'b0;
    total++;
    if (product !== 16'd0) begin
      bad++; $display("FAIL pp_idle_addA: got %h want 0000", product);
    end
    for (int i = 0; i < W; i++) begin
      total++;
      if (lsb1 !== 1'((bm >> i) & 1) || doneAdd !== 1'b0) begin
        bad++; $display("FAIL pp_iter%0d: lsb1=%b done=%b want lsb1=%0d done=0",
                        i, lsb1, doneAdd, (bm >> i) & 1);
      end
      shift(1'((bm >> i) & 1));
    end
    total++;
    if (doneAdd !== 1'b1 || product !== 16'd15) begin
      bad++; $display("FAIL pp_result: done=%b prod=%h want done=1 prod=000f", doneAdd, product);
    end
    // further strobes after completion are ignored
    for (int i = 0; i < 3; i++) shift(1'b1);
    total++;
    if (doneAdd !== 1'b1 || product !== 16'd15 || lsb1 !== 1'b0) begin
      bad++; $display("FAIL pp_saturate: done=%b prod=%h lsb1=%b want 1/000f/0",
                      doneAdd, product, lsb1);
    end
  endtask

  task automatic test_neg_pos();
    int bm = 5;
    load(8'hFD, 8'd5);
    total++;
    if ({flipA, flipB} !== 2'b10) begin
      bad++; $display("FAIL np_flags: got %b%b want 10", flipA, flipB);
    end
    for (int i = 0; i < W; i++) shift(1'((bm >> i) & 1));
    total++;
    if (product !== 16'd15) begin
      bad++; $display("FAIL np_mag: got %h want 000f", product);
    end
    flip();
    total++;
    if (product !== 16'hFFF1) begin
      bad++; $display("FAIL np_flip: got %h want fff1", product);
    end
    step();
    total++;
    if (product !== 16'hFFF1) begin
      bad++; $display("FAIL np_hold: got %h want fff1", product);
    end
  endtask

  task automatic test_min_min();
    int bm = 128;
    load(8'h80, 8'h80);
    total++;
    if ({flipA, flipB} !== 2'b11) begin
      bad++; $display("FAIL mm_flags: got %b%b want 11", flipA, flipB);
    end
    for (int i = 0; i < W; i++) begin
      total++;
      if (lsb1 !== 1'((bm >> i) & 1)) begin
        bad++; $display("FAIL mm_lsb_iter%0d: got %b want %0d", i, lsb1, (bm >> i) & 1);
      end
      shift(1'((bm >> i) & 1));
    end
    total++;
    if (doneAdd !== 1'b1 || product !== 16'd16384) begin
      bad++; $display("FAIL mm_result: done=%b prod=%h want 1/4000", doneAdd, product);
    end
  endtask

  task automatic test_zero_neg1();
    int bm = 1;
    load(8'd0, 8'hFF);
    total++;
    if ({flipA, flipB} !== 2'b01 || lsb1 !== 1'b1) begin
      bad++; $display("FAIL zn_load: flags=%b%b lsb1=%b want 01/1", flipA, flipB, lsb1);
    end
    for (int i = 0; i < W; i++) shift(1'((bm >> i) & 1));
    total++;
    if (product !== 16'd0) begin
      bad++; $display("FAIL zn_mag: got %h want 0000", product);
    end
    flip();
    total++;
    if (product !== 16'd0) begin
      bad++; $display("FAIL zn_flip: got %h want 0000", product);
    end
  endtask

  task automatic test_restart();
    int bm = 5;
    int bn = 9;
    load(8'd3, 8'd5);
    for (int i = 0; i < 4; i++) shift(1'((bm >> i) & 1));
    total++;
    if (product !== 16'd15) begin
      bad++; $display("FAIL rs_partial: got %h want 000f", product);
    end
    load(8'd7, 8'd9);
    total++;
    if (doneAdd !== 1'b0 || lsb1 !== 1'b1 || product !== 16'd0 || {flipA, flipB} !== 2'b00) begin
      bad++; $display("FAIL rs_reload: done=%b lsb1=%b prod=%h flags=%b%b want 0/1/0000/00",
                      doneAdd, lsb1, product, flipA, flipB);
    end
    for (int i = 0; i < W; i++) begin
      total++;
      if (lsb1 !== 1'((bn >> i) & 1) || doneAdd !== 1'b0) begin
        bad++; $display("FAIL rs_iter%0d: lsb1=%b done=%b want lsb1=%0d done=0",
                        i, lsb1, doneAdd, (bn >> i) & 1);
      end
      shift(1'((bn >> i) & 1));
    end
    total++;
    if (doneAdd !== 1'b1 || product !== 16'd63) begin
      bad++; $display("FAIL rs_result: done=%b prod=%h want 1/003f", doneAdd, product);
    end
  endtask

  task automatic test_async_reset();
    int bm = 5;
    load(8'hFD, 8'hFB);
    for (int i = 0; i < 3; i++) shift(1'((bm >> i) & 1));
    total++;
    if (product !== 16'd15 || {flipA, flipB} !== 2'b11) begin
      bad++; $display("FAIL ar_pre: prod=%h flags=%b%b want 000f/11", product, flipA, flipB);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({lsb1, doneAdd, flipA, flipB, product} !== 20'h0) begin
      bad++; $display("FAIL ar_immediate: lsb1=%b done=%b fA=%b fB=%b prod=%h want all 0",
                      lsb1, doneAdd, flipA, flipB, product);
    end
    #2 reset = 1'b0;
    step();
    for (int i = 0; i < W; i++) shift(1'b1);
    total++;
    if (product !== 16'd0 || doneAdd !== 1'b1 || lsb1 !== 1'b0) begin
      bad++; $display("FAIL ar_no_load: prod=%h done=%b lsb1=%b want 0000/1/0",
                      product, doneAdd, lsb1);
    end
  endtask

  initial begin
    test_reset();
    test_pos_pos();
    test_neg_pos();
    test_min_min();
    test_zero_neg1();
    test_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
